// File: rtl/snax_hwpe_tcdm_bridge.sv
// snax_hwpe_tcdm_bridge: per-channel bridge from HWPE TCDM master ports
// (req/gnt, r_valid) to reqrsp TCDM ports (q_valid/q_ready, p_valid).
// Each channel owns a request FIFO without fall-through and a credit counter
// that bounds the number of reads in flight. Responses pass straight through.

package snax_hwpe_tcdm_bridge_pkg;

    typedef enum logic [3:0] {
        AMONone = 4'h0,
        AMOSwap = 4'h1,
        AMOAdd  = 4'h2,
        AMOAnd  = 4'h3,
        AMOOr   = 4'h4,
        AMOXor  = 4'h5,
        AMOMax  = 4'h6,
        AMOMaxu = 4'h7,
        AMOMin  = 4'h8,
        AMOMinu = 4'h9,
        AMOLR   = 4'hA,
        AMOSC   = 4'hB
    } amo_op_e;

    // Default reqrsp channel types for AddrWidth=32, DataWidth=64.
    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        amo_op_e     amo;
        logic [63:0] data;
        logic [7:0]  strb;
        logic        user;
    } tcdm_req_chan_t;

    typedef struct packed {
        tcdm_req_chan_t q;
        logic           q_valid;
    } tcdm_req_t;

    typedef struct packed {
        logic [63:0] data;
    } tcdm_rsp_chan_t;

    typedef struct packed {
        logic           q_ready;
        tcdm_rsp_chan_t p;
        logic           p_valid;
    } tcdm_rsp_t;

endpackage

module snax_hwpe_tcdm_bridge #(
    parameter int unsigned NumChannels    = 4,
    parameter int unsigned AddrWidth      = 32,
    parameter int unsigned DataWidth      = 64,
    parameter int unsigned FifoDepth      = 4,
    parameter int unsigned MaxOutstanding = 8,
    parameter type tcdm_req_t = snax_hwpe_tcdm_bridge_pkg::tcdm_req_t,
    parameter type tcdm_rsp_t = snax_hwpe_tcdm_bridge_pkg::tcdm_rsp_t,
    localparam int unsigned StrbWidth = DataWidth / 8
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic [NumChannels-1:0]           hwpe_req_i,
    output logic [NumChannels-1:0]           hwpe_gnt_o,
    input  logic [NumChannels*AddrWidth-1:0] hwpe_add_i,
    input  logic [NumChannels-1:0]           hwpe_wen_i,
    input  logic [NumChannels*StrbWidth-1:0] hwpe_be_i,
    input  logic [NumChannels*DataWidth-1:0] hwpe_data_i,
    output logic [NumChannels*DataWidth-1:0] hwpe_r_data_o,
    output logic [NumChannels-1:0]           hwpe_r_valid_o,
    output tcdm_req_t                        tcdm_req_o [NumChannels],
    input  tcdm_rsp_t                        tcdm_rsp_i [NumChannels],
    output logic                             busy_o
);

    localparam int unsigned PtrW = $clog2(FifoDepth);
    localparam int unsigned CntW = $clog2(FifoDepth + 1);
    localparam int unsigned OutW = $clog2(MaxOutstanding + 1);

    // Parameter sanity, rejected at elaboration.
    if (DataWidth % 8 != 0) begin : g_err_data_width
        $error("snax_hwpe_tcdm_bridge: DataWidth must be a multiple of 8");
    end
    if (FifoDepth < 2) begin : g_err_fifo_depth
        $error("snax_hwpe_tcdm_bridge: FifoDepth must be at least 2");
    end
    if (MaxOutstanding < 1) begin : g_err_max_outstanding
        $error("snax_hwpe_tcdm_bridge: MaxOutstanding must be at least 1");
    end

    logic [NumChannels-1:0] busy_ch;

    for (genvar c = 0; c < NumChannels; c++) begin : g_ch

        // Request FIFO storage; data words are never reset, only the pointers.
        logic [AddrWidth-1:0] addr_mem  [FifoDepth];
        logic                 write_mem [FifoDepth];
        logic [DataWidth-1:0] data_mem  [FifoDepth];
        logic [StrbWidth-1:0] strb_mem  [FifoDepth];

        logic [PtrW-1:0] wr_ptr;
        logic [PtrW-1:0] rd_ptr;
        logic [CntW-1:0] fill;
        logic [OutW-1:0] outstanding;

        logic      fifo_full;
        logic      fifo_empty;
        logic      credit_ok;
        logic      is_read;
        logic      push;
        logic      pop;
        logic      read_push;
        logic      rsp_taken;
        tcdm_req_t req_d;

        assign is_read    = hwpe_wen_i[c];
        assign fifo_full  = (fill == CntW'(FifoDepth));
        assign fifo_empty = (fill == '0);
        assign credit_ok  = (outstanding < OutW'(MaxOutstanding));

        // Fullness is the registered fill level, so a pop in this cycle does
        // not reopen the grant until the next one.
        assign hwpe_gnt_o[c] = hwpe_req_i[c] & ~fifo_full & (is_read ? credit_ok : 1'b1);

        assign push      = hwpe_gnt_o[c];
        assign pop       = ~fifo_empty & tcdm_rsp_i[c].q_ready;
        assign read_push = push & is_read;
        // A response with no read in flight is ignored so the counter
        // saturates at zero instead of wrapping.
        assign rsp_taken = tcdm_rsp_i[c].p_valid & (outstanding != '0);

        // Write a granted request into the slot at the write pointer.
        always_ff @(posedge clk_i) begin
            if (push) begin
                addr_mem[wr_ptr]  <= hwpe_add_i[c*AddrWidth +: AddrWidth];
                write_mem[wr_ptr] <= ~hwpe_wen_i[c];
                data_mem[wr_ptr]  <= hwpe_data_i[c*DataWidth +: DataWidth];
                strb_mem[wr_ptr]  <= hwpe_be_i[c*StrbWidth +: StrbWidth];
            end
        end

        // FIFO pointers and fill level; pointers wrap for any depth.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                fill   <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= (wr_ptr == PtrW'(FifoDepth - 1)) ? '0 : wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= (rd_ptr == PtrW'(FifoDepth - 1)) ? '0 : rd_ptr + 1'b1;
                end
                case ({push, pop})
                    2'b10:   fill <= fill + 1'b1;
                    2'b01:   fill <= fill - 1'b1;
                    default: fill <= fill;
                endcase
            end
        end

        // Reads take credit when they are queued and return it on response.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                outstanding <= '0;
            end else begin
                case ({read_push, rsp_taken})
                    2'b10:   outstanding <= outstanding + 1'b1;
                    2'b01:   outstanding <= outstanding - 1'b1;
                    default: outstanding <= outstanding;
                endcase
            end
        end

        // Present the FIFO head on the reqrsp request channel.
        always_comb begin
            req_d         = '0;
            req_d.q_valid = ~fifo_empty;
            req_d.q.addr  = addr_mem[rd_ptr];
            req_d.q.write = write_mem[rd_ptr];
            req_d.q.amo   = snax_hwpe_tcdm_bridge_pkg::AMONone;
            req_d.q.data  = data_mem[rd_ptr];
            req_d.q.strb  = strb_mem[rd_ptr];
            req_d.q.user  = '0;
        end

        assign tcdm_req_o[c] = req_d;

        assign hwpe_r_data_o[c*DataWidth +: DataWidth] = tcdm_rsp_i[c].p.data;
        assign hwpe_r_valid_o[c]                       = tcdm_rsp_i[c].p_valid;

        assign busy_ch[c] = ~fifo_empty | (outstanding != '0);

        // The TCDM side must never answer more reads than were issued.
        a_no_spurious_rsp : assert property (
            @(posedge clk_i) disable iff (!rst_ni)
            tcdm_rsp_i[c].p_valid |-> (outstanding != '0)
        ) else $error("snax_hwpe_tcdm_bridge ch%0d: p_valid with no read outstanding", c);

    end

    assign busy_o = |busy_ch;

endmodule

// File: tb/tb_snax_hwpe_tcdm_bridge.sv
// Bench for snax_hwpe_tcdm_bridge: directed steps plus a random phase, with
// per-channel scoreboards for requests seen on the reqrsp side and read data.

module tb_snax_hwpe_tcdm_bridge;

    localparam int NC = 4;
    localparam int AW = 32;
    localparam int DW = 64;
    localparam int SW = 8;

    typedef snax_hwpe_tcdm_bridge_pkg::tcdm_req_t req_t;
    typedef snax_hwpe_tcdm_bridge_pkg::tcdm_rsp_t rsp_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [NC-1:0]   req, gnt, wen, r_valid;
    logic [NC*AW-1:0] add;
    logic [NC*SW-1:0] be;
    logic [NC*DW-1:0] wdata, r_data;
    req_t            tq [NC];
    rsp_t            tr [NC];
    logic            busy;
    logic [NC-1:0]   qv;

    int n_tests = 0;
    int n_fail  = 0;

    logic [104:0] exp_req_q [NC][$];
    logic [63:0]  exp_rsp_q [NC][$];
    logic [31:0]  pend_q    [NC][$];

    snax_hwpe_tcdm_bridge dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .hwpe_req_i     (req),
        .hwpe_gnt_o     (gnt),
        .hwpe_add_i     (add),
        .hwpe_wen_i     (wen),
        .hwpe_be_i      (be),
        .hwpe_data_i    (wdata),
        .hwpe_r_data_o  (r_data),
        .hwpe_r_valid_o (r_valid),
        .tcdm_req_o     (tq),
        .tcdm_rsp_i     (tr),
        .busy_o         (busy)
    );

    always #5 clk = ~clk;

    always_comb begin
        qv = '0;
        for (int c = 0; c < NC; c++) qv[c] = tq[c].q_valid;
    end

    function automatic logic [63:0] rdata(input logic [31:0] a);
        return {a ^ 32'hA5A5_0000, ~a};
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic set_req(input int c, input logic r, input logic w, input logic [31:0] a,
                           input logic [7:0] b, input logic [63:0] d);
        req[c]           = r;
        wen[c]           = w;
        add[c*AW +: AW]  = a;
        be[c*SW +: SW]   = b;
        wdata[c*DW +: DW] = d;
    endtask

    // Record what a granted request must look like at the reqrsp side.
    task automatic note_push(input int c, input logic [63:0] rsp);
        if (gnt[c]) begin
            exp_req_q[c].push_back({add[c*AW +: AW], ~wen[c], be[c*SW +: SW], wdata[c*DW +: DW]});
            if (wen[c]) exp_rsp_q[c].push_back(rsp);
        end
    endtask

    // Memory model: answer the oldest accepted read when enabled.
    task automatic respond(input int c, input bit en);
        if (en && pend_q[c].size() > 0) begin
            tr[c].p_valid = 1'b1;
            tr[c].p.data  = rdata(pend_q[c].pop_front());
        end else begin
            tr[c].p_valid = 1'b0;
            tr[c].p.data  = '0;
        end
    endtask

    task automatic drain(input int c);
        tr[c].q_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            mid();
            if (!qv[c]) break;
            tick();
        end
        check($sformatf("drain_qvalid_ch%0d", c), qv[c], 0);
        check($sformatf("drain_sb_ch%0d", c), exp_req_q[c].size(), 0);
        tick();
        tr[c].q_ready = 1'b0;
    endtask

    // Scoreboard: compare reqrsp requests and read data as they appear.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int c = 0; c < NC; c++) begin
                if (tq[c].q_valid && tr[c].q_ready) begin
                    if (exp_req_q[c].size() == 0) begin
                        check($sformatf("unexpected_req_ch%0d", c), 1, 0);
                    end else begin
                        check($sformatf("req_ch%0d", c),
                              {tq[c].q.addr, tq[c].q.write, tq[c].q.strb, tq[c].q.data},
                              exp_req_q[c].pop_front());
                        check($sformatf("amo_user_ch%0d", c), {tq[c].q.amo, tq[c].q.user}, 0);
                        if (!tq[c].q.write) pend_q[c].push_back(tq[c].q.addr);
                    end
                end
                if (r_valid[c]) begin
                    if (exp_rsp_q[c].size() == 0) begin
                        check($sformatf("unexpected_rsp_ch%0d", c), 1, 0);
                    end else begin
                        check($sformatf("rdata_ch%0d", c), r_data[c*DW +: DW], exp_rsp_q[c].pop_front());
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  issued [NC];
        bit  done;
        req = '0; wen = '0; add = '0; be = '0; wdata = '0;
        for (int c = 0; c < NC; c++) tr[c] = '0;

        // Reset state
        rst_n = 1'b0;
        tick(); tick(); mid();
        check("rst_qvalid", qv, 0);
        check("rst_busy", busy, 0);
        check("rst_gnt_idle", gnt, 0);
        tick();
        set_req(0, 1, 0, 32'h10, 8'hFF, 64'h1);
        set_req(1, 1, 1, 32'h20, 8'hFF, 64'h0);
        tr[2].p_valid = 1'b1;
        tr[2].p.data  = 64'h55;
        mid();
        check("rst_gnt", gnt, 4'b0011);
        check("rst_rvalid", r_valid, 4'b0100);
        check("rst_rdata", r_data[2*DW +: DW], 64'h55);
        tick();
        req = '0;
        tr[2].p_valid = 1'b0;
        tr[2].p.data  = '0;
        rst_n = 1'b1;

        // Ch0 single write
        tick();
        set_req(0, 1, 0, 32'h100, 8'h0F, 64'hDEAD_BEEF);
        mid();
        check("t1_gnt", gnt[0], 1);
        check("t1_no_fallthrough", qv[0], 0);
        note_push(0, 64'h0);
        tick();
        req[0] = 1'b0;
        tr[0].q_ready = 1'b1;
        mid();
        check("t1_qvalid", qv[0], 1);
        check("t1_write", tq[0].q.write, 1);
        check("t1_strb", tq[0].q.strb, 8'h0F);
        tick();
        tr[0].q_ready = 1'b0;
        mid();
        check("t1_empty", qv[0], 0);
        check("t1_busy", busy, 0);

        // Ch1 single read
        tick();
        set_req(1, 1, 1, 32'h200, 8'hFF, 64'h0);
        mid();
        check("t2_gnt", gnt[1], 1);
        note_push(1, 64'h1234);
        tick();
        req[1] = 1'b0;
        tr[1].q_ready = 1'b1;
        mid();
        check("t2_qvalid", qv[1], 1);
        check("t2_busy_fifo", busy, 1);
        tick();
        tr[1].q_ready = 1'b0;
        mid();
        check("t2_busy_inflight", busy, 1);
        tick();
        tr[1].p_valid = 1'b1;
        tr[1].p.data  = 64'h1234;
        void'(pend_q[1].pop_front());
        mid();
        check("t2_rvalid", r_valid[1], 1);
        check("t2_rdata", r_data[1*DW +: DW], 64'h1234);
        tick();
        tr[1].p_valid = 1'b0;
        tr[1].p.data  = '0;
        mid();
        check("t2_busy_idle", busy, 0);

        // Ch2 FIFO full, no same-cycle bypass
        for (int i = 0; i < 4; i++) begin
            tick();
            set_req(2, 1, 0, 32'h300 + 32'(8 * i), 8'hFF, 64'hC0DE_0000 + 64'(i));
            mid();
            check($sformatf("t3_gnt%0d", i), gnt[2], 1);
            note_push(2, 64'h0);
        end
        tick();
        set_req(2, 1, 0, 32'h320, 8'h33, 64'hFEED);
        mid();
        check("t3_full_gnt", gnt[2], 0);
        tick(); mid();
        check("t3_full_hold", gnt[2], 0);
        tick();
        tr[2].q_ready = 1'b1;
        mid();
        check("t3_no_bypass", gnt[2], 0);
        tick();
        tr[2].q_ready = 1'b0;
        mid();
        check("t3_regrant", gnt[2], 1);
        note_push(2, 64'h0);
        tick();
        req[2] = 1'b0;
        drain(2);

        // Ch3 credit limit
        tr[3].q_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            set_req(3, 1, 1, 32'h400 + 32'(8 * i), 8'hFF, 64'h0);
            mid();
            check($sformatf("t4_gnt%0d", i), gnt[3], 1);
            note_push(3, rdata(32'h400 + 32'(8 * i)));
        end
        tick();
        set_req(3, 1, 1, 32'h440, 8'hFF, 64'h0);
        mid();
        check("t4_credit_block", gnt[3], 0);
        tick();
        set_req(3, 1, 0, 32'h500, 8'h0F, 64'hABCD);
        mid();
        check("t4_write_ok", gnt[3], 1);
        note_push(3, 64'h0);
        tick();
        set_req(3, 1, 1, 32'h440, 8'hFF, 64'h0);
        respond(3, 1);
        mid();
        check("t4_same_cycle_block", gnt[3], 0);
        tick();
        respond(3, 0);
        mid();
        check("t4_credit_return", gnt[3], 1);
        note_push(3, rdata(32'h440));
        tick();
        req[3] = 1'b0;
        for (int k = 0; k < 60; k++) begin
            respond(3, 1);
            mid();
            if (exp_rsp_q[3].size() == 0) break;
            tick();
        end
        check("t4_all_rsp", exp_rsp_q[3].size(), 0);
        tick();
        respond(3, 0);
        tr[3].q_ready = 1'b0;
        mid();
        check("t4_busy_idle", busy, 0);

        // All channels, random readiness and response delays
        for (int c = 0; c < NC; c++) issued[c] = 0;
        done = 1'b0;
        for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
            tick();
            for (int c = 0; c < NC; c++) begin
                if (issued[c] < 6 && $urandom_range(1, 0) == 1)
                    set_req(c, 1, 1, (32'(c) << 28) | ($urandom & 32'h0FFF_FFF8), 8'hFF, 64'h0);
                else
                    req[c] = 1'b0;
                tr[c].q_ready = 1'($urandom_range(1, 0));
                respond(c, $urandom_range(2, 0) == 0);
            end
            mid();
            for (int c = 0; c < NC; c++) begin
                if (gnt[c]) begin
                    note_push(c, rdata(add[c*AW +: AW]));
                    issued[c]++;
                end
            end
            done = 1'b1;
            for (int c = 0; c < NC; c++)
                if (issued[c] < 6 || exp_rsp_q[c].size() != 0) done = 1'b0;
        end
        check("t5_done", done, 1);
        tick();
        req = '0;
        for (int c = 0; c < NC; c++) begin
            respond(c, 0);
            tr[c].q_ready = 1'b0;
        end
        mid();
        check("t5_busy_idle", busy, 0);

        // Reset with queued and in-flight reads on ch0
        tr[0].q_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            set_req(0, 1, 1, 32'h700 + 32'(8 * i), 8'hFF, 64'h0);
            mid();
            check($sformatf("t6_gnt_a%0d", i), gnt[0], 1);
            note_push(0, rdata(32'h700 + 32'(8 * i)));
        end
        tick();
        req[0] = 1'b0;
        mid();
        for (int i = 0; i < 3; i++) begin
            tick();
            tr[0].q_ready = 1'b0;
            set_req(0, 1, 1, 32'h780 + 32'(8 * i), 8'hFF, 64'h0);
            mid();
            check($sformatf("t6_gnt_b%0d", i), gnt[0], 1);
            note_push(0, rdata(32'h780 + 32'(8 * i)));
        end
        tick();
        req[0] = 1'b0;
        check("t6_busy_before", busy, 1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_qvalid", qv[0], 0);
        check("t6_rst_busy", busy, 0);
        for (int c = 0; c < NC; c++) begin
            exp_req_q[c].delete();
            exp_rsp_q[c].delete();
            pend_q[c].delete();
        end
        tick();
        rst_n = 1'b1;
        tick();
        set_req(0, 1, 0, 32'h800, 8'hFF, 64'h77);
        mid();
        check("t6_gnt_after_rst", gnt[0], 1);
        note_push(0, 64'h0);
        tick();
        req[0] = 1'b0;
        drain(0);
        mid();
        check("t6_busy_idle", busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
